// File: rtl/datamover_cmd_responder_if.sv
// Bundles the command, data and status streams of both datamover channels.
// The slave modport is the responder; the master modport is whoever drives commands and data.
interface datamover_cmd_responder_if;
    logic [63:0] s_axis_mm2s_cmd_tdata;
    logic        s_axis_mm2s_cmd_tvalid;
    logic        s_axis_mm2s_cmd_tready;
    logic [63:0] s_axis_s2mm_cmd_tdata;
    logic        s_axis_s2mm_cmd_tvalid;
    logic        s_axis_s2mm_cmd_tready;

    logic [31:0] m_axis_mm2s_tdata;
    logic [3:0]  m_axis_mm2s_tkeep;
    logic        m_axis_mm2s_tlast;
    logic        m_axis_mm2s_tvalid;
    logic        m_axis_mm2s_tready;

    logic [31:0] s_axis_s2mm_tdata;
    logic [3:0]  s_axis_s2mm_tkeep;
    logic        s_axis_s2mm_tlast;
    logic        s_axis_s2mm_tvalid;
    logic        s_axis_s2mm_tready;

    logic [7:0]  m_axis_mm2s_sts_tdata;
    logic        m_axis_mm2s_sts_tvalid;
    logic        m_axis_mm2s_sts_tready;
    logic [7:0]  m_axis_s2mm_sts_tdata;
    logic        m_axis_s2mm_sts_tvalid;
    logic        m_axis_s2mm_sts_tready;

    logic        mm2s_rd_xfer_cmplt;
    logic        s2mm_wr_xfer_cmplt;

    modport slave (
        input  s_axis_mm2s_cmd_tdata, s_axis_mm2s_cmd_tvalid,
        output s_axis_mm2s_cmd_tready,
        input  s_axis_s2mm_cmd_tdata, s_axis_s2mm_cmd_tvalid,
        output s_axis_s2mm_cmd_tready,
        output m_axis_mm2s_tdata, m_axis_mm2s_tkeep, m_axis_mm2s_tlast, m_axis_mm2s_tvalid,
        input  m_axis_mm2s_tready,
        input  s_axis_s2mm_tdata, s_axis_s2mm_tkeep, s_axis_s2mm_tlast, s_axis_s2mm_tvalid,
        output s_axis_s2mm_tready,
        output m_axis_mm2s_sts_tdata, m_axis_mm2s_sts_tvalid,
        input  m_axis_mm2s_sts_tready,
        output m_axis_s2mm_sts_tdata, m_axis_s2mm_sts_tvalid,
        input  m_axis_s2mm_sts_tready,
        output mm2s_rd_xfer_cmplt, s2mm_wr_xfer_cmplt
    );

    modport master (
        output s_axis_mm2s_cmd_tdata, s_axis_mm2s_cmd_tvalid,
        input  s_axis_mm2s_cmd_tready,
        output s_axis_s2mm_cmd_tdata, s_axis_s2mm_cmd_tvalid,
        input  s_axis_s2mm_cmd_tready,
        input  m_axis_mm2s_tdata, m_axis_mm2s_tkeep, m_axis_mm2s_tlast, m_axis_mm2s_tvalid,
        output m_axis_mm2s_tready,
        output s_axis_s2mm_tdata, s_axis_s2mm_tkeep, s_axis_s2mm_tlast, s_axis_s2mm_tvalid,
        input  s_axis_s2mm_tready,
        input  m_axis_mm2s_sts_tdata, m_axis_mm2s_sts_tvalid,
        output m_axis_mm2s_sts_tready,
        input  m_axis_s2mm_sts_tdata, m_axis_s2mm_sts_tvalid,
        output m_axis_s2mm_sts_tready,
        input  mm2s_rd_xfer_cmplt, s2mm_wr_xfer_cmplt
    );
endinterface

// File: rtl/datamover_cmd_responder.sv
// Datamover command responder: MM2S generates address-pattern read data, S2MM sinks write
// data and checks its length; each channel reports a status byte and a completion pulse.
//
// state    | meaning
// RD_IDLE  | mm2s command ready (after first post-reset edge)
// RD_WAIT  | start latency down-count before first read beat
// RD_DATA  | presenting read beats, advance on tvalid & tready
// RD_STS   | mm2s status valid until sts_tready
// WR_IDLE  | s2mm command ready (after first post-reset edge)
// WR_DATA  | accepting write beats until tlast
// WR_STS   | s2mm status valid until sts_tready
module datamover_cmd_responder #(
    parameter int DATA_WIDTH    = 32,
    parameter int START_LATENCY = 4
) (
    input logic clk,
    input logic rst_n,
    datamover_cmd_responder_if.slave bus
);
    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA, RD_STS} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_STS} wr_state_t;

    localparam logic [31:0] BEAT_BYTES = 32'(DATA_WIDTH / 8);
    localparam logic [3:0]  WAIT_LOAD  = (START_LATENCY > 0) ? 4'(START_LATENCY - 1) : 4'd0;

    function automatic logic [20:0] beats_of(input logic [22:0] btt);
        logic [23:0] sum;
        sum = {1'b0, btt} + 24'd3;
        return sum[22:2];
    endfunction

    rd_state_t   rd_state_q, rd_state_d;
    wr_state_t   wr_state_q, wr_state_d;
    logic        rdy_q, rdy_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [20:0] rd_rem_q, rd_rem_d;
    logic [3:0]  rd_wait_q, rd_wait_d;
    logic [1:0]  rd_btt_lo_q, rd_btt_lo_d;
    logic        rd_decerr_q, rd_decerr_d;
    logic        rd_cmplt_q, rd_cmplt_d;
    logic [20:0] wr_rem_q, wr_rem_d;
    logic        wr_ovr_q, wr_ovr_d;
    logic        wr_decerr_q, wr_decerr_d;
    logic        wr_interr_q, wr_interr_d;
    logic        wr_cmplt_q, wr_cmplt_d;

    logic        rd_last;
    logic [3:0]  rd_keep_last;
    logic        rd_bad_cmd;
    logic        wr_bad_cmd;

    // rdy_q holds cmd_tready low during reset and releases it on the first edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q  <= RD_IDLE;
            wr_state_q  <= WR_IDLE;
            rdy_q       <= 1'b0;
            rd_addr_q   <= '0;
            rd_rem_q    <= '0;
            rd_wait_q   <= '0;
            rd_btt_lo_q <= '0;
            rd_decerr_q <= 1'b0;
            rd_cmplt_q  <= 1'b0;
            wr_rem_q    <= '0;
            wr_ovr_q    <= 1'b0;
            wr_decerr_q <= 1'b0;
            wr_interr_q <= 1'b0;
            wr_cmplt_q  <= 1'b0;
        end else begin
            rd_state_q  <= rd_state_d;
            wr_state_q  <= wr_state_d;
            rdy_q       <= rdy_d;
            rd_addr_q   <= rd_addr_d;
            rd_rem_q    <= rd_rem_d;
            rd_wait_q   <= rd_wait_d;
            rd_btt_lo_q <= rd_btt_lo_d;
            rd_decerr_q <= rd_decerr_d;
            rd_cmplt_q  <= rd_cmplt_d;
            wr_rem_q    <= wr_rem_d;
            wr_ovr_q    <= wr_ovr_d;
            wr_decerr_q <= wr_decerr_d;
            wr_interr_q <= wr_interr_d;
            wr_cmplt_q  <= wr_cmplt_d;
        end
    end

    assign rdy_d = 1'b1;
    assign bus.mm2s_rd_xfer_cmplt = rd_cmplt_q;
    assign bus.s2mm_wr_xfer_cmplt = wr_cmplt_q;

    assign rd_last      = (rd_rem_q == 21'd1);
    assign rd_keep_last = (rd_btt_lo_q == 2'd0) ? 4'hF : ((4'd1 << rd_btt_lo_q) - 4'd1);
    assign rd_bad_cmd   = (bus.s_axis_mm2s_cmd_tdata[22:0] == 23'd0) | ~bus.s_axis_mm2s_cmd_tdata[23];
    assign wr_bad_cmd   = (bus.s_axis_s2mm_cmd_tdata[22:0] == 23'd0) | ~bus.s_axis_s2mm_cmd_tdata[23];

    always_comb begin
        rd_state_d  = rd_state_q;
        rd_addr_d   = rd_addr_q;
        rd_rem_d    = rd_rem_q;
        rd_wait_d   = rd_wait_q;
        rd_btt_lo_d = rd_btt_lo_q;
        rd_decerr_d = rd_decerr_q;
        rd_cmplt_d  = 1'b0;
        bus.s_axis_mm2s_cmd_tready = 1'b0;
        bus.m_axis_mm2s_tdata      = '0;
        bus.m_axis_mm2s_tkeep      = '0;
        bus.m_axis_mm2s_tlast      = 1'b0;
        bus.m_axis_mm2s_tvalid     = 1'b0;
        bus.m_axis_mm2s_sts_tdata  = '0;
        bus.m_axis_mm2s_sts_tvalid = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                bus.s_axis_mm2s_cmd_tready = rdy_q;
                if (rdy_q && bus.s_axis_mm2s_cmd_tvalid) begin
                    rd_addr_d   = bus.s_axis_mm2s_cmd_tdata[63:32];
                    rd_rem_d    = beats_of(bus.s_axis_mm2s_cmd_tdata[22:0]);
                    rd_btt_lo_d = bus.s_axis_mm2s_cmd_tdata[1:0];
                    rd_wait_d   = WAIT_LOAD;
                    rd_decerr_d = rd_bad_cmd;
                    if (rd_bad_cmd)              rd_state_d = RD_STS;
                    else if (START_LATENCY == 0) rd_state_d = RD_DATA;
                    else                         rd_state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_wait_q == 4'd0) rd_state_d = RD_DATA;
                else                   rd_wait_d  = rd_wait_q - 4'd1;
            end
            RD_DATA: begin
                bus.m_axis_mm2s_tvalid = 1'b1;
                bus.m_axis_mm2s_tdata  = rd_addr_q;
                bus.m_axis_mm2s_tlast  = rd_last;
                bus.m_axis_mm2s_tkeep  = rd_last ? rd_keep_last : 4'hF;
                if (bus.m_axis_mm2s_tready) begin
                    rd_addr_d = rd_addr_q + BEAT_BYTES;
                    rd_rem_d  = rd_rem_q - 21'd1;
                    if (rd_last) rd_state_d = RD_STS;
                end
            end
            RD_STS: begin
                bus.m_axis_mm2s_sts_tvalid = 1'b1;
                bus.m_axis_mm2s_sts_tdata  = {~rd_decerr_q, 1'b0, rd_decerr_q, 1'b0, 4'h0};
                if (bus.m_axis_mm2s_sts_tready) begin
                    rd_cmplt_d = 1'b1;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Overrun is sticky: once the expected count is used up, further beats are discarded.
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_rem_d    = wr_rem_q;
        wr_ovr_d    = wr_ovr_q;
        wr_decerr_d = wr_decerr_q;
        wr_interr_d = wr_interr_q;
        wr_cmplt_d  = 1'b0;
        bus.s_axis_s2mm_cmd_tready = 1'b0;
        bus.s_axis_s2mm_tready     = 1'b0;
        bus.m_axis_s2mm_sts_tdata  = '0;
        bus.m_axis_s2mm_sts_tvalid = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                bus.s_axis_s2mm_cmd_tready = rdy_q;
                if (rdy_q && bus.s_axis_s2mm_cmd_tvalid) begin
                    wr_rem_d    = beats_of(bus.s_axis_s2mm_cmd_tdata[22:0]);
                    wr_ovr_d    = 1'b0;
                    wr_interr_d = 1'b0;
                    wr_decerr_d = wr_bad_cmd;
                    wr_state_d  = wr_bad_cmd ? WR_STS : WR_DATA;
                end
            end
            WR_DATA: begin
                bus.s_axis_s2mm_tready = 1'b1;
                if (bus.s_axis_s2mm_tvalid) begin
                    if (bus.s_axis_s2mm_tlast) begin
                        wr_interr_d = wr_ovr_q | (wr_rem_q != 21'd1);
                        wr_state_d  = WR_STS;
                    end else if (wr_rem_q <= 21'd1) begin
                        wr_ovr_d = 1'b1;
                    end else begin
                        wr_rem_d = wr_rem_q - 21'd1;
                    end
                end
            end
            WR_STS: begin
                bus.m_axis_s2mm_sts_tvalid = 1'b1;
                bus.m_axis_s2mm_sts_tdata  = {~(wr_decerr_q | wr_interr_q), 1'b0,
                                              wr_decerr_q, wr_interr_q, 4'h0};
                if (bus.m_axis_s2mm_sts_tready) begin
                    wr_cmplt_d = 1'b1;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end
endmodule

// File: tb/tb_datamover_cmd_responder.sv
// Directed, table-driven bench for datamover_cmd_responder with hand sequences for
// simultaneous commands and mid-transfer reset.
module tb_datamover_cmd_responder;
    localparam int LAT = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    datamover_cmd_responder_if dut_if ();

    datamover_cmd_responder #(.DATA_WIDTH(32), .START_LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          ch;        // 0 = mm2s, 1 = s2mm
        logic [31:0] saddr;
        logic [22:0] btt;
        bit          typ;
        bit          eof;
        bit          bp;        // mm2s: toggle tready; s2mm: idle gap between beats
        int          n;         // mm2s: expected beats; s2mm: beats sent
        logic [3:0]  keep_last;
        logic [7:0]  sts;
        int          hold;      // cycles sts_tready held low
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {3'b0,
                dut_if.s_axis_mm2s_cmd_tready, dut_if.s_axis_s2mm_cmd_tready,
                dut_if.m_axis_mm2s_tdata, dut_if.m_axis_mm2s_tkeep,
                dut_if.m_axis_mm2s_tlast, dut_if.m_axis_mm2s_tvalid,
                dut_if.s_axis_s2mm_tready,
                dut_if.m_axis_mm2s_sts_tdata, dut_if.m_axis_mm2s_sts_tvalid,
                dut_if.m_axis_s2mm_sts_tdata, dut_if.m_axis_s2mm_sts_tvalid,
                dut_if.mm2s_rd_xfer_cmplt, dut_if.s2mm_wr_xfer_cmplt};
    endfunction

    function automatic logic [63:0] mk_cmd(input vec_t v);
        return {v.saddr, 1'b0, v.eof, 6'b0, v.typ, v.btt};
    endfunction

    task automatic send_cmd(input bit ch, input logic [63:0] cmd);
        int k;
        logic rdy;
        k = 0;
        if (ch) begin dut_if.s_axis_s2mm_cmd_tdata = cmd; dut_if.s_axis_s2mm_cmd_tvalid = 1'b1; end
        else    begin dut_if.s_axis_mm2s_cmd_tdata = cmd; dut_if.s_axis_mm2s_cmd_tvalid = 1'b1; end
        rdy = ch ? dut_if.s_axis_s2mm_cmd_tready : dut_if.s_axis_mm2s_cmd_tready;
        while (!rdy && k < 20) begin
            tick();
            k++;
            rdy = ch ? dut_if.s_axis_s2mm_cmd_tready : dut_if.s_axis_mm2s_cmd_tready;
        end
        check("cmd_tready", {63'b0, rdy}, 64'd1);
        tick();
        dut_if.s_axis_mm2s_cmd_tvalid = 1'b0;
        dut_if.s_axis_s2mm_cmd_tvalid = 1'b0;
    endtask

    task automatic finish_sts(input bit ch, input logic [7:0] exp, input int hold);
        int   k;
        logic sv;
        k  = 0;
        sv = ch ? dut_if.m_axis_s2mm_sts_tvalid : dut_if.m_axis_mm2s_sts_tvalid;
        while (!sv && k < 50) begin
            tick();
            k++;
            sv = ch ? dut_if.m_axis_s2mm_sts_tvalid : dut_if.m_axis_mm2s_sts_tvalid;
        end
        check("sts_tvalid", {63'b0, sv}, 64'd1);
        for (int h = 0; h < hold; h++) begin
            check("sts_hold_valid", {63'b0, ch ? dut_if.m_axis_s2mm_sts_tvalid : dut_if.m_axis_mm2s_sts_tvalid}, 64'd1);
            check("sts_hold_cmplt", {63'b0, ch ? dut_if.s2mm_wr_xfer_cmplt : dut_if.mm2s_rd_xfer_cmplt}, 64'd0);
            tick();
        end
        check("sts_tdata", {56'b0, ch ? dut_if.m_axis_s2mm_sts_tdata : dut_if.m_axis_mm2s_sts_tdata}, {56'b0, exp});
        if (ch) dut_if.m_axis_s2mm_sts_tready = 1'b1;
        else    dut_if.m_axis_mm2s_sts_tready = 1'b1;
        tick();
        dut_if.m_axis_s2mm_sts_tready = 1'b0;
        dut_if.m_axis_mm2s_sts_tready = 1'b0;
        check("cmplt_pulse", {63'b0, ch ? dut_if.s2mm_wr_xfer_cmplt : dut_if.mm2s_rd_xfer_cmplt}, 64'd1);
        check("sts_drop", {63'b0, ch ? dut_if.m_axis_s2mm_sts_tvalid : dut_if.m_axis_mm2s_sts_tvalid}, 64'd0);
        tick();
        check("cmplt_one_cycle", {63'b0, ch ? dut_if.s2mm_wr_xfer_cmplt : dut_if.mm2s_rd_xfer_cmplt}, 64'd0);
    endtask

    task automatic run_mm2s(input vec_t v);
        int   cyc, beat, first;
        logic rdy;
        logic [31:0] exp_data;
        send_cmd(1'b0, mk_cmd(v));
        cyc = 0; beat = 0; first = -1;
        while (!dut_if.m_axis_mm2s_sts_tvalid && cyc < 100) begin
            rdy = v.bp ? cyc[0] : 1'b1;
            dut_if.m_axis_mm2s_tready = rdy;
            if (dut_if.m_axis_mm2s_tvalid) begin
                if (first < 0) first = cyc;
                exp_data = v.saddr + 32'(4 * beat);
                check("mm2s_tdata", {32'b0, dut_if.m_axis_mm2s_tdata}, {32'b0, exp_data});
                check("mm2s_tkeep", {60'b0, dut_if.m_axis_mm2s_tkeep},
                      {60'b0, (beat == v.n - 1) ? v.keep_last : 4'hF});
                check("mm2s_tlast", {63'b0, dut_if.m_axis_mm2s_tlast}, {63'b0, beat == v.n - 1});
                if (rdy) beat++;
            end
            tick();
            cyc++;
        end
        dut_if.m_axis_mm2s_tready = 1'b0;
        if (cyc >= 100) check("mm2s_timeout", 64'd0, 64'd1);
        check("mm2s_beats", 64'(beat), 64'(v.n));
        check("mm2s_latency", 64'(first), (v.n > 0) ? 64'(LAT) : 64'(-1));
        finish_sts(1'b0, v.sts, v.hold);
    endtask

    task automatic run_s2mm(input vec_t v);
        int k;
        send_cmd(1'b1, mk_cmd(v));
        for (int i = 0; i < v.n; i++) begin
            if (v.bp && i > 0) tick();
            dut_if.s_axis_s2mm_tdata  = 32'(i);
            dut_if.s_axis_s2mm_tkeep  = 4'hF;
            dut_if.s_axis_s2mm_tlast  = (i == v.n - 1);
            dut_if.s_axis_s2mm_tvalid = 1'b1;
            k = 0;
            while (!dut_if.s_axis_s2mm_tready && k < 20) begin tick(); k++; end
            check("s2mm_tready", {63'b0, dut_if.s_axis_s2mm_tready}, 64'd1);
            tick();
            dut_if.s_axis_s2mm_tvalid = 1'b0;
            dut_if.s_axis_s2mm_tlast  = 1'b0;
        end
        finish_sts(1'b1, v.sts, v.hold);
    endtask

    initial begin
        int k;
        checks = 0;
        errors = 0;
        //          ch    saddr          btt     typ   eof   bp    n  keep   sts    hold
        vecs[0]  = '{1'b0, 32'h1000_0000, 23'd16, 1'b1, 1'b0, 1'b0, 4, 4'hF, 8'h80, 0};
        vecs[1]  = '{1'b0, 32'hFFFF_FFFC, 23'd6,  1'b1, 1'b0, 1'b1, 2, 4'h3, 8'h80, 0};
        vecs[2]  = '{1'b0, 32'h0000_0100, 23'd5,  1'b1, 1'b1, 1'b0, 2, 4'h1, 8'h80, 1};
        vecs[3]  = '{1'b0, 32'h0000_0040, 23'd3,  1'b1, 1'b0, 1'b1, 1, 4'h7, 8'h80, 0};
        vecs[4]  = '{1'b0, 32'h0000_0000, 23'd0,  1'b1, 1'b0, 1'b0, 0, 4'hF, 8'h20, 5};
        vecs[5]  = '{1'b0, 32'h0000_2000, 23'd8,  1'b0, 1'b0, 1'b0, 0, 4'hF, 8'h20, 0};
        vecs[6]  = '{1'b1, 32'h0,         23'd12, 1'b1, 1'b0, 1'b0, 3, 4'hF, 8'h80, 0};
        vecs[7]  = '{1'b1, 32'h0,         23'd12, 1'b1, 1'b0, 1'b1, 2, 4'hF, 8'h10, 0};
        vecs[8]  = '{1'b1, 32'h0,         23'd8,  1'b1, 1'b0, 1'b0, 4, 4'hF, 8'h10, 0};
        vecs[9]  = '{1'b1, 32'h0,         23'd1,  1'b1, 1'b1, 1'b0, 1, 4'hF, 8'h80, 0};
        vecs[10] = '{1'b1, 32'h0,         23'd0,  1'b1, 1'b0, 1'b0, 0, 4'hF, 8'h20, 2};
        vecs[11] = '{1'b1, 32'h0,         23'd4,  1'b0, 1'b0, 1'b0, 0, 4'hF, 8'h20, 0};

        rst_n = 1'b0;
        dut_if.s_axis_mm2s_cmd_tdata  = '0; dut_if.s_axis_mm2s_cmd_tvalid = 1'b0;
        dut_if.s_axis_s2mm_cmd_tdata  = '0; dut_if.s_axis_s2mm_cmd_tvalid = 1'b0;
        dut_if.m_axis_mm2s_tready     = 1'b0;
        dut_if.s_axis_s2mm_tdata      = '0; dut_if.s_axis_s2mm_tkeep = '0;
        dut_if.s_axis_s2mm_tlast      = 1'b0; dut_if.s_axis_s2mm_tvalid = 1'b0;
        dut_if.m_axis_mm2s_sts_tready = 1'b0; dut_if.m_axis_s2mm_sts_tready = 1'b0;

        tick(); tick(); tick();
        check("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        check("ready_before_edge", {62'b0, dut_if.s_axis_mm2s_cmd_tready, dut_if.s_axis_s2mm_cmd_tready}, 64'd0);
        tick();
        check("ready_after_edge", {62'b0, dut_if.s_axis_mm2s_cmd_tready, dut_if.s_axis_s2mm_cmd_tready}, 64'd3);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].ch) run_s2mm(vecs[i]);
            else            run_mm2s(vecs[i]);
        end

        // Simultaneous commands, then reset during MM2S beat 2.
        dut_if.s_axis_mm2s_cmd_tdata  = {32'h0000_2000, 1'b0, 1'b0, 6'b0, 1'b1, 23'd16};
        dut_if.s_axis_s2mm_cmd_tdata  = {32'h0, 1'b0, 1'b0, 6'b0, 1'b1, 23'd16};
        dut_if.s_axis_mm2s_cmd_tvalid = 1'b1;
        dut_if.s_axis_s2mm_cmd_tvalid = 1'b1;
        check("dual_ready", {62'b0, dut_if.s_axis_mm2s_cmd_tready, dut_if.s_axis_s2mm_cmd_tready}, 64'd3);
        tick();
        dut_if.s_axis_mm2s_cmd_tvalid = 1'b0;
        dut_if.s_axis_s2mm_cmd_tvalid = 1'b0;
        check("dual_accepted", {62'b0, dut_if.s_axis_mm2s_cmd_tready, dut_if.s_axis_s2mm_cmd_tready}, 64'd0);
        dut_if.m_axis_mm2s_tready = 1'b1;
        k = 0;
        while (!(dut_if.m_axis_mm2s_tvalid && dut_if.m_axis_mm2s_tdata == 32'h0000_2008) && k < 40) begin
            tick();
            k++;
        end
        check("beat2_reached", {32'b0, dut_if.m_axis_mm2s_tdata}, 64'h2008);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", all_outs(), 64'd0);
        dut_if.m_axis_mm2s_tready = 1'b0;
        dut_if.m_axis_mm2s_sts_tready = 1'b1;
        dut_if.m_axis_s2mm_sts_tready = 1'b1;
        tick(); tick();
        check("abort_hold", all_outs(), 64'd0);
        rst_n = 1'b1;
        check("abort_ready_low", {62'b0, dut_if.s_axis_mm2s_cmd_tready, dut_if.s_axis_s2mm_cmd_tready}, 64'd0);
        tick();
        check("abort_ready_high", {62'b0, dut_if.s_axis_mm2s_cmd_tready, dut_if.s_axis_s2mm_cmd_tready}, 64'd3);
        for (int i = 0; i < 3; i++) begin
            check("abort_no_status", {60'b0, dut_if.m_axis_mm2s_sts_tvalid, dut_if.m_axis_s2mm_sts_tvalid,
                                      dut_if.mm2s_rd_xfer_cmplt, dut_if.s2mm_wr_xfer_cmplt}, 64'd0);
            tick();
        end
        dut_if.m_axis_mm2s_sts_tready = 1'b0;
        dut_if.m_axis_s2mm_sts_tready = 1'b0;

        run_mm2s(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/datamover_cmd_responder.md
DATAMOVER_CMD_RESPONDER -- requirements
Module: datamover_cmd_responder

Interface
REQ-001 Parameter: DATA_WIDTH, 32, MM2S/S2MM data stream width in bits; only 32 is supported, giving 4 bytes per beat.
REQ-002 Parameter: START_LATENCY, 4, idle cycles between command acceptance and the first MM2S data beat; valid range 0..15.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 s_axis_mm2s_cmd_tdata  input  64  read command.
REQ-006 s_axis_mm2s_cmd_tvalid / s_axis_mm2s_cmd_tready  input / output  1 / 1  read command handshake.
REQ-007 s_axis_s2mm_cmd_tdata  input  64  write command.
REQ-008 s_axis_s2mm_cmd_tvalid / s_axis_s2mm_cmd_tready  input / output  1 / 1  write command handshake.
REQ-009 m_axis_mm2s_tdata / tkeep / tlast / tvalid  output  32 / 4 / 1 / 1  read data stream.
REQ-010 m_axis_mm2s_tready  input  1  read data backpressure.
REQ-011 s_axis_s2mm_tdata / tkeep / tlast / tvalid  input  32 / 4 / 1 / 1  write data stream.
REQ-012 s_axis_s2mm_tready  output  1  write data acceptance.
REQ-013 m_axis_mm2s_sts_tdata / m_axis_s2mm_sts_tdata  output  8 / 8  status bytes.
REQ-014 m_axis_mm2s_sts_tvalid / m_axis_s2mm_sts_tvalid  output  1 / 1  status valid, one per channel.
REQ-015 m_axis_mm2s_sts_tready / m_axis_s2mm_sts_tready  input  1 / 1  status ready, one per channel.
REQ-016 mm2s_rd_xfer_cmplt / s2mm_wr_xfer_cmplt  output  1 / 1  one-cycle completion pulses.

Function
REQ-017 Command decode SHALL be identical on both channels: BTT = tdata[22:0]; TYPE = tdata[23]; EOF = tdata[30]; SADDR = tdata[63:32]; all other bits ignored.
REQ-018 Each channel SHALL be an independent FSM with states IDLE, WAIT (MM2S only), DATA, STS.
REQ-019 cmd_tready SHALL be 1 only in IDLE; a command is accepted on the cycle tvalid and tready are both 1, and BTT/SADDR are latched on that cycle.
REQ-020 Beat count SHALL be (BTT+3)>>2, held in a 21-bit register.
REQ-021 On accept, a channel with BTT==0 or TYPE==0 SHALL go directly to STS with DECERR=1; its data stream is never asserted.
REQ-022 MM2S: accept -> WAIT for exactly START_LATENCY cycles -> DATA; with START_LATENCY=0 the channel goes directly to DATA.
REQ-023 MM2S DATA: beat i (counting from 0) SHALL carry tdata = SADDR + 4*i (mod 2^32).
REQ-024 MM2S DATA: tkeep=4'hF on every beat except the last; on the last beat tkeep has its low (BTT mod 4) bits set, or 4'hF when (BTT mod 4)==0.
REQ-025 MM2S DATA: tlast=1 on the last beat only.
REQ-026 MM2S DATA: tvalid is held and tdata/tkeep/tlast are stable while tready==0; the beat advances only on tvalid&tready; the channel goes to STS after the last beat.
REQ-027 S2MM DATA: s_axis_s2mm_tready=1; the channel counts accepted beats and leaves DATA on an accepted beat carrying tlast=1.
REQ-028 S2MM INTERR: set when the accepted count at tlast != expected beats.
REQ-029 S2MM overrun: if the expected count is reached without tlast, the channel keeps accepting and discarding beats until tlast, and INTERR is set.
REQ-030 Status byte SHALL be {OKAY[7], SLVERR[6]=0, DECERR[5], INTERR[4], TAG[3:0]=0}, with OKAY = ~(DECERR|INTERR).
REQ-031 In STS, sts_tvalid=1 and sts_tdata is held until sts_tready=1.
REQ-032 On the sts handshake cycle, xfer_cmplt SHALL pulse high for exactly one cycle (registered, visible the next cycle) and the FSM returns to IDLE.
REQ-033 The two channels SHALL never block one another; simultaneous commands on both channels are both accepted on the same cycle.
REQ-034 EOF SHALL have no effect on behaviour.

Reset
REQ-035 While rst_n==0: both FSMs are in IDLE; all counters, latched fields and error flags are 0.
REQ-036 While rst_n==0: every output is 0, including cmd_tready.
REQ-037 cmd_tready SHALL rise on the first clock edge after rst_n deasserts.
REQ-038 Reset asserted mid-transfer SHALL abort immediately; no status and no cmplt pulse are emitted for the aborted command.

Verification
REQ-039 MM2S cmd {SADDR=0x1000_0000, TYPE=1, BTT=16}, tready=1 -> after 4 idle cycles, 4 beats 0x10000000..0x1000000C, tkeep=F, tlast on beat 3; then sts=0x80; then a one-cycle mm2s_rd_xfer_cmplt.
REQ-040 MM2S BTT=6, SADDR=0xFFFF_FFFC, tready toggling every cycle -> beats 0xFFFFFFFC then 0x00000000 with tkeep=4'h3 and tlast; data held stable while stalled.
REQ-041 S2MM cmd BTT=12 with 3 beats, tlast on beat 3 -> sts=0x80, s2mm_wr_xfer_cmplt pulse; then 2 beats with tlast on beat 2 -> sts=0x10.
REQ-042 MM2S cmd with BTT=0 -> no data beats, sts=0x20; with sts_tready held low for 5 cycles, sts_tvalid stays high and cmplt pulses once after the handshake.
REQ-043 Both commands presented on the same cycle -> both cmd_tready handshakes complete that cycle; rst_n pulled low during MM2S beat 2 -> all outputs 0, no cmplt pulse, cmd_tready=1 on the first edge after release.
